// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: shares one AHB slave port among MASTER_NUM masters with round-robin grant and burst/lock hold
//   hclk, hreset_n            : clock, async active-low reset
//   hreq, htrans_m, hburst_m  : per-master request, transfer type and burst type for this slave
//   hlock, hready             : per-master lock request, slave hreadyout
//   hgrant, hmaster_addr      : registered one-hot address-phase grant and its index
//   hmaster_data(_valid)      : data-phase owner index and data-phase active flag
module ahb_slave_arbiter #(
  parameter int MASTER_NUM = 4,
  parameter int MASTER_ID_WIDTH = $clog2(MASTER_NUM)
) (
  input  logic                            hclk,
  input  logic                            hreset_n,
  input  logic [MASTER_NUM-1:0]           hreq,
  input  logic [MASTER_NUM-1:0][1:0]      htrans_m,
  input  logic [MASTER_NUM-1:0][2:0]      hburst_m,
  input  logic [MASTER_NUM-1:0]           hlock,
  input  logic                            hready,
  output logic [MASTER_NUM-1:0]           hgrant,
  output logic [MASTER_ID_WIDTH-1:0]      hmaster_addr,
  output logic [MASTER_ID_WIDTH-1:0]      hmaster_data,
  output logic                            hmaster_data_valid
);
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10;
  localparam logic [2:0] INCR = 3'b001;
  logic [MASTER_ID_WIDTH-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, data_owner_q, win, idx;
  logic                       owner_valid_q, owner_valid_d, data_valid_q, found, own_req, accept, hold;
  logic [1:0]                 tr;
  logic [2:0]                 bu;
  logic [3:0]                 beat_cnt_q, beat_cnt_d, len_m1;
  assign tr = htrans_m[owner_q];
  assign bu = hburst_m[owner_q];
  assign own_req = owner_valid_q && hreq[owner_q];
  assign accept = hready && own_req && tr[1];
  assign hmaster_addr = owner_q;
  assign hmaster_data = data_owner_q;
  assign hmaster_data_valid = data_valid_q;
  // Scan downward in offset so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      idx = MASTER_ID_WIDTH'((int'(rr_ptr_q) + i) % MASTER_NUM);
      if (hreq[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // INCR has no fixed length and loads 0; it is held by its own rule instead of the counter.
  always_comb begin
    len_m1 = bu[2:1] == 2'd0 ? 4'd0 : bu[2:1] == 2'd1 ? 4'd3 : bu[2:1] == 2'd2 ? 4'd7 : 4'd15;
    beat_cnt_d = !accept ? beat_cnt_q : tr == NONSEQ ? len_m1 : beat_cnt_q == 4'd0 ? 4'd0 : beat_cnt_q - 4'd1;
    hold = own_req && (hlock[owner_q] || (tr != IDLE && (bu == INCR || beat_cnt_d != 4'd0 || tr == BUSY)));
    owner_d = hold || !found ? owner_q : win;
    owner_valid_d = hold || found;
    rr_ptr_d = hold || !found ? rr_ptr_q : MASTER_ID_WIDTH'((int'(win) + 1) % MASTER_NUM);
    hgrant = '0;
    if (owner_valid_q) hgrant[owner_q] = 1'b1;
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      owner_q <= '0;
      owner_valid_q <= 1'b0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else if (hready) begin
      owner_q <= owner_d;
      owner_valid_q <= owner_valid_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      data_owner_q <= owner_q;
      data_valid_q <= accept;
    end
  end
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter: directed self-checking bench for ahb_slave_arbiter
module tb_ahb_slave_arbiter;
  logic            hclk = 1'b0, hreset_n = 1'b0, hready = 1'b1, hmaster_data_valid;
  logic [3:0]      hreq = '0, hlock = '0, hgrant;
  logic [3:0][1:0] htrans_m = '0;
  logic [3:0][2:0] hburst_m = '0;
  logic [1:0]      hmaster_addr, hmaster_data;
  logic [8:0]      obs;
  int              total = 0, bad = 0;
  assign obs = {hgrant, hmaster_addr, hmaster_data, hmaster_data_valid};
  always #5 hclk = ~hclk;
  ahb_slave_arbiter dut (
    .hclk(hclk), .hreset_n(hreset_n), .hreq(hreq), .htrans_m(htrans_m), .hburst_m(hburst_m),
    .hlock(hlock), .hready(hready), .hgrant(hgrant), .hmaster_addr(hmaster_addr),
    .hmaster_data(hmaster_data), .hmaster_data_valid(hmaster_data_valid)
  );
  task automatic tick;
    @(posedge hclk);
    #1;
  endtask
  task automatic drop(input logic [1:0] m);
    hreq[m] = 1'b0;
    htrans_m[m] = 2'b00;
  endtask
  task automatic do_reset;
    hreset_n = 1'b0;
    hreq = '0; htrans_m = '0; hburst_m = '0; hlock = '0; hready = 1'b1;
    tick();
    hreset_n = 1'b1;
  endtask
  task automatic test_reset;
    logic [8:0] ev [6];
    ev = '{9'b0001_00_00_0, 9'b0010_01_00_1, 9'b0100_10_01_1, 9'b1000_11_10_1, 9'b1000_11_11_1, 9'b0000_11_11_0};
    hreset_n = 1'b0;
    hreq = 4'b1111;
    htrans_m = {4{2'b10}};
    hburst_m = '0;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (obs !== 9'd0) begin bad++; $display("FAIL reset_hold c%0d got=%b exp=%b", c, obs, 9'd0); end
    end
    hreset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 2) drop(2'(c - 2));
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL reset_rr c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
  endtask
  task automatic test_simultaneous;
    logic [8:0] ev [4];
    ev = '{9'b0010_01_00_0, 9'b0100_10_01_1, 9'b0100_10_10_1, 9'b0000_10_10_0};
    do_reset();
    hreq = 4'b0110;
    htrans_m[1] = 2'b10;
    htrans_m[2] = 2'b10;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) drop(2'd1);
      if (c == 3) drop(2'd2);
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL simul c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
  endtask
  task automatic test_burst;
    logic [8:0] ev [6];
    ev = '{9'b0001_00_00_0, 9'b0001_00_00_1, 9'b0001_00_00_1, 9'b0001_00_00_1, 9'b1000_11_00_1, 9'b1000_11_11_1};
    do_reset();
    hreq = 4'b1001;
    htrans_m[0] = 2'b10;
    hburst_m[0] = 3'b011;
    htrans_m[3] = 2'b10;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) htrans_m[0] = 2'b11;
      if (c == 5) drop(2'd0);
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL incr4 c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
  endtask
  task automatic test_wait;
    logic [8:0] ev [9];
    ev = '{9'b0001_00_00_0, 9'b0001_00_00_1, 9'b0001_00_00_1, 9'b0001_00_00_1, 9'b0001_00_00_1,
           9'b0001_00_00_1, 9'b0001_00_00_1, 9'b1000_11_00_1, 9'b1000_11_11_1};
    do_reset();
    hreq = 4'b1001;
    htrans_m[0] = 2'b10;
    hburst_m[0] = 3'b011;
    htrans_m[3] = 2'b10;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) htrans_m[0] = 2'b11;
      if (c == 3) hready = 1'b0;
      if (c == 6) hready = 1'b1;
      if (c == 8) drop(2'd0);
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL wait c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
  endtask
  task automatic test_busy;
    logic [8:0] ev [6];
    ev = '{9'b0100_10_00_0, 9'b0100_10_10_1, 9'b0100_10_10_1, 9'b0100_10_10_0, 9'b0010_01_10_0, 9'b0010_01_01_1};
    do_reset();
    hreq = 4'b0100;
    htrans_m[2] = 2'b10;
    hburst_m[2] = 3'b001;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin hreq[1] = 1'b1; htrans_m[1] = 2'b10; end
      if (c == 2) htrans_m[2] = 2'b11;
      if (c == 3) htrans_m[2] = 2'b01;
      if (c == 4) drop(2'd2);
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL incr_busy c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
  endtask
  task automatic test_lock;
    logic [8:0] ev [3];
    ev = '{9'b0010_01_00_0, 9'b0010_01_01_1, 9'b0010_01_01_1};
    do_reset();
    hreq = 4'b0010;
    htrans_m[1] = 2'b10;
    hlock[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin hreq[0] = 1'b1; htrans_m[0] = 2'b10; end
      tick();
      total++;
      if (obs !== ev[c]) begin bad++; $display("FAIL lock c%0d got=%b exp=%b", c, obs, ev[c]); end
    end
    hreset_n = 1'b0;
    #2;
    total++;
    if (obs !== 9'd0) begin bad++; $display("FAIL async_reset got=%b exp=%b", obs, 9'd0); end
    hreset_n = 1'b1;
    tick();
    total++;
    if (obs !== 9'b0001_00_00_0) begin bad++; $display("FAIL post_reset got=%b exp=%b", obs, 9'b0001_00_00_0); end
  endtask
  initial begin
    test_reset();
    test_simultaneous();
    test_burst();
    test_wait();
    test_busy();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave AHB arbiter that shares one slave port among `MASTER_NUM` masters. It sits behind the per-master address decoders: each decoder's `hreq` bit for this slave forms one request line. The arbiter grants the slave address phase to one master at a time, holds the grant across fixed-length bursts, undefined-length bursts and locked sequences, and tracks the data-phase owner so the data mux can route `hrdata`/`hwdata`.

## Interface
- `MASTER_NUM`, 4, number of requesting masters (≥2)
- `MASTER_ID_WIDTH`, `$clog2(MASTER_NUM)`, width of master index outputs
- `hclk`  in  1  clock, rising edge
- `hreset_n`  in  1  reset, asynchronous, active-low
- `hreq`  in  `MASTER_NUM`  per-master request for this slave (decoder output, already gated by `htrans != IDLE`)
- `htrans_m`  in  `[MASTER_NUM-1:0][1:0]`  per-master `htrans_type`: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- `hburst_m`  in  `[MASTER_NUM-1:0][2:0]`  per-master burst: SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111
- `hlock`  in  `MASTER_NUM`  per-master locked-transfer request
- `hready`  in  1  slave `hreadyout`; all state advances only when 1
- `hgrant`  out  `MASTER_NUM`  one-hot (or zero) address-phase grant, registered
- `hmaster_addr`  out  `MASTER_ID_WIDTH`  index of granted master
- `hmaster_data`  out  `MASTER_ID_WIDTH`  index of data-phase owner
- `hmaster_data_valid`  out  1  data phase of this slave is active

## Operation
- Registers: `owner` (index), `owner_valid`, `rr_ptr`, `beat_cnt` (4 bits), `data_owner`, `data_valid`.
- `hgrant = owner_valid ? (1 << owner) : 0`; `hmaster_addr = owner`.
- Beat accepted: `hready && owner_valid && hreq[owner] && htrans_m[owner] ∈ {NONSEQ, SEQ}`.
- Beat counter: accepted NONSEQ loads `len-1` (len: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=0 special); accepted SEQ decrements, saturating at 0; BUSY holds.
- Hold (no re-arbitration) when `owner_valid && hreq[owner]` and any of:
  - `hlock[owner]`;
  - `hburst_m[owner]==INCR` and `htrans_m[owner] ∈ {NONSEQ, SEQ, BUSY}`;
  - fixed burst and next `beat_cnt ≠ 0`, or `htrans_m[owner]==BUSY`.
- Otherwise re-arbitrate at the `hready` edge: round-robin scan of `hreq` from `rr_ptr` upward (wrapping); winner → `owner`, `owner_valid=1`, `rr_ptr=winner+1 mod MASTER_NUM`. No requester → `owner_valid=0`, `rr_ptr` unchanged.
- Owner dropping `hreq` (address left this slave) or driving IDLE ends the hold immediately; early burst termination is legal.
- Data phase: at every `hready` edge, `data_owner <= owner`, `data_valid <= beat accepted`.
- `hready=0`: every register holds, including grant; no grant change during wait states.

## Timing
- Reset: `hgrant=0`, `hmaster_addr=0`, `hmaster_data=0`, `hmaster_data_valid=0`, `beat_cnt=0`, `rr_ptr=0`. Asserting `hreset_n` mid-burst clears everything at once; the first arbitration after release starts from master 0.
- Grant latency: `hreq` seen at an arbitrating `hready` edge → `hgrant` high from the following cycle. The master's pending NONSEQ is accepted at the next `hready` edge. Its data phase (`hmaster_data_valid=1`) is the cycle after that.
- Back-to-back handover: the last accepted beat of A and the grant to B take effect at the same edge. A's data phase overlaps B's address phase with no idle cycle.
- Sole continuous requester re-wins every arbitration (no bubble).
- Simultaneous requests at the same edge: lowest index at or above `rr_ptr` wins.
- An accepted SINGLE or the final fixed-burst beat releases at that same edge.

## Test plan
- Reset: drive `hreq=4'b1111` during reset → all outputs 0; first edge after release grants master 0, then 1, 2, 3 on successive single transfers (round-robin).
- Masters 1 and 2 request simultaneously, SINGLE NONSEQ, `rr_ptr=0` → master 1 granted first, master 2 next; `hmaster_data` follows each `hmaster_addr` by exactly one `hready` edge.
- Master 0 INCR4 (NONSEQ + 3 SEQ) while master 3 requests → `hgrant=0001` for all 4 beats. Grant moves to `1000` at the edge accepting the 4th beat.
- Same INCR4 with `hready` low 3 cycles after beat 2 → `hgrant`, `beat_cnt` and data outputs frozen; the burst completes with 4 accepted beats.
- Master 2 INCR with a BUSY beat, then IDLE; master 1 requesting → held through BUSY, released at the IDLE edge; `hmaster_data_valid=0` for the BUSY beat's data phase.
- `hlock[1]=1` across two SINGLE transfers while master 0 requests → master 1 keeps the grant. `hreset_n` pulsed low mid-sequence → `hgrant=0` immediately (asynchronously), not at the next edge.
